// File: rtl/frame_capture_if.sv
// Sample/readout bundle between the counter-side producer, frame_capture and the frame reader.
interface frame_capture_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic                  clk_enable;
  logic [5:0]            count;
  logic [DATA_WIDTH-1:0] sample_in;
  logic [5:0]            rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  frame_release;
  logic                  frame_valid;
  logic                  overrun;
  logic                  sync_err;

  modport master (
    output clk_enable, count, sample_in, rd_addr, frame_release,
    input  rd_data, frame_valid, overrun, sync_err
  );

  modport slave (
    input  clk_enable, count, sample_in, rd_addr, frame_release,
    output rd_data, frame_valid, overrun, sync_err
  );
endinterface

// File: rtl/frame_capture.sv
// Ping-pong 64-sample frame capture aligned to the 6-bit sample counter, with
// discontinuity detection and drop-on-overrun when the reader still holds a frame.
module frame_capture #(
  parameter int DATA_WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  frame_capture_if.slave bus
);
  localparam int FRAME_LEN = 64;

  typedef enum logic {SYNC = 1'b0, FILL = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [5:0]            wr_idx;
  logic [5:0]            exp_idx, exp_nxt;
  logic                  wr_en, complete, seq_err, accept, drop, valid_nxt;
  logic                  wr_bank, rd_bank;
  logic                  frame_valid_p1, overrun_p1, sync_err_p1;
  logic [DATA_WIDTH-1:0] rd_data_p1;
  logic [DATA_WIDTH-1:0] mem [0:2*FRAME_LEN-1];

  // Sample lands where the counter is about to move on this edge.
  assign wr_idx = bus.count + 6'd1;

  always_comb begin
    state_nxt = state;
    exp_nxt   = exp_idx;
    wr_en     = 1'b0;
    complete  = 1'b0;
    seq_err   = 1'b0;
    if (bus.clk_enable) begin
      unique case (state)
        SYNC: begin
          if (wr_idx == 6'd0) begin
            wr_en     = 1'b1;
            exp_nxt   = 6'd1;
            state_nxt = FILL;
          end
        end
        FILL: begin
          if (wr_idx == exp_idx) begin
            wr_en    = 1'b1;
            exp_nxt  = exp_idx + 6'd1;
            complete = (wr_idx == 6'(FRAME_LEN - 1));
          end else begin
            seq_err = 1'b1;
            if (wr_idx == 6'd0) begin
              wr_en   = 1'b1;
              exp_nxt = 6'd1;
            end else begin
              state_nxt = SYNC;
            end
          end
        end
        default: state_nxt = SYNC;
      endcase
    end

    // A release in the completion cycle frees the held bank just in time.
    accept = complete && (!frame_valid_p1 || bus.frame_release);
    drop   = complete && !accept;
    if (accept)
      valid_nxt = 1'b1;
    else if (bus.frame_release)
      valid_nxt = 1'b0;
    else
      valid_nxt = frame_valid_p1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= SYNC;
      exp_idx        <= 6'd0;
      wr_bank        <= 1'b0;
      rd_bank        <= 1'b0;
      frame_valid_p1 <= 1'b0;
      overrun_p1     <= 1'b0;
      sync_err_p1    <= 1'b0;
      rd_data_p1     <= '0;
    end else begin
      state          <= state_nxt;
      exp_idx        <= exp_nxt;
      frame_valid_p1 <= valid_nxt;
      overrun_p1     <= drop;
      sync_err_p1    <= seq_err;
      rd_data_p1     <= mem[{rd_bank, bus.rd_addr}];
      if (accept) begin
        rd_bank <= wr_bank;
        wr_bank <= ~wr_bank;
      end
    end
  end

  // Frame storage: bank select is the address MSB.
  always_ff @(posedge clk) begin
    if (rst && wr_en)
      mem[{wr_bank, wr_idx}] <= bus.sample_in;
  end

  assign bus.rd_data     = rd_data_p1;
  assign bus.frame_valid = frame_valid_p1;
  assign bus.overrun     = overrun_p1;
  assign bus.sync_err    = sync_err_p1;
endmodule

// File: tb/tb_frame_capture.sv
// Bench for frame_capture: vector table, directed frame sequences and randomized
// strobes against a queue-based frame model.
module tb_frame_capture;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  frame_capture_if #(.DATA_WIDTH(16)) bus ();
  frame_capture #(.DATA_WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Model: partial frame as a queue, held frame as an array.
  logic [15:0] q[$];
  logic [15:0] held[64];
  bit          synced;
  bit          m_valid;

  typedef struct {
    bit         r;
    bit         en;
    logic [5:0] c;
    bit         rel;
    bit         ev;
    bit         eo;
    bit         es;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit en, input logic [5:0] c, input logic [15:0] s,
                      input logic [5:0] ra, input bit rel);
    logic [5:0]  w;
    bit          comp, ovr, se, rd_chk;
    logic [15:0] rd_exp;
    rst               = r;
    bus.clk_enable    = en;
    bus.count         = c;
    bus.sample_in     = s;
    bus.rd_addr       = ra;
    bus.frame_release = rel;
    rd_chk = m_valid;
    rd_exp = held[ra];
    ovr = 1'b0;
    se  = 1'b0;
    comp = 1'b0;
    if (!r) begin
      q.delete();
      synced  = 1'b0;
      m_valid = 1'b0;
      rd_chk  = 1'b1;
      rd_exp  = 16'h0;
    end else begin
      if (en) begin
        w = c + 6'd1;
        if (!synced) begin
          if (w == 6'd0) begin
            q.delete();
            q.push_back(s);
            synced = 1'b1;
          end
        end else if (int'(w) == q.size()) begin
          q.push_back(s);
          if (q.size() == 64) comp = 1'b1;
        end else begin
          se = 1'b1;
          q.delete();
          if (w == 6'd0) q.push_back(s);
          else synced = 1'b0;
        end
      end
      if (comp) begin
        if (!m_valid || rel) begin
          for (int i = 0; i < 64; i++) held[i] = q[i];
          m_valid = 1'b1;
        end else begin
          ovr = 1'b1;
        end
        q.delete();
      end else if (rel) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("frame_valid", bus.frame_valid, m_valid);
    chk("overrun", bus.overrun, ovr);
    chk("sync_err", bus.sync_err, se);
    if (rd_chk) chk("rd_data", bus.rd_data, rd_exp);
  endtask

  task automatic fill_frame(input logic [15:0] base, input bit rel_last);
    for (int k = 0; k < 64; k++)
      step(1'b1, 1'b1, 6'(k + 63), base + 16'(k), 6'd0, rel_last && (k == 63));
  endtask

  task automatic read_frame(input logic [15:0] base);
    for (int k = 0; k < 64; k++) begin
      step(1'b1, 1'b0, 6'd0, 16'h0, 6'(k), 1'b0);
      chk("rd_frame", bus.rd_data, base + 16'(k));
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 6'd0, 16'h0, 6'd0, 1'b0);
    step(1'b0, 1'b0, 6'd0, 16'h0, 6'd0, 1'b0);
  endtask

  initial begin
    int rc;
    synced  = 1'b0;
    m_valid = 1'b0;
    for (int i = 0; i < 64; i++) held[i] = 16'h0;
    rst = 1'b0;
    bus.clk_enable = 1'b0;
    bus.count = 6'd0;
    bus.sample_in = 16'h0;
    bus.rd_addr = 6'd0;
    bus.frame_release = 1'b0;

    //           r  en  c       rel ev eo es
    vecs[0]  = '{1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 6'd10, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 6'd62, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 6'd63, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 6'd5,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 6'd1,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 6'd5,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 6'd2,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 6'd63, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 6'd63, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 6'd1,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 6'd3,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[17] = '{1'b1, 1'b1, 6'd4,  1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].r, vecs[i].en, vecs[i].c, 16'($urandom), 6'($urandom_range(0, 63)), vecs[i].rel);
      chk($sformatf("vec%0d_valid", i), bus.frame_valid, vecs[i].ev);
      chk($sformatf("vec%0d_overrun", i), bus.overrun, vecs[i].eo);
      chk($sformatf("vec%0d_sync_err", i), bus.sync_err, vecs[i].es);
    end
    chk("reset_rd_data", 32'(vecs[0].r), 32'(1'b0));

    // Aligned frame, sample = index, then read it back.
    do_reset();
    chk("rd_data_after_reset", bus.rd_data, 16'h0);
    fill_frame(16'h0000, 1'b0);
    chk("t1_valid", bus.frame_valid, 1'b1);
    read_frame(16'h0000);

    // Discontinuity at exp=20: count 21 instead of 19.
    do_reset();
    for (int k = 0; k < 20; k++) step(1'b1, 1'b1, 6'(k + 63), 16'(k), 6'd0, 1'b0);
    step(1'b1, 1'b1, 6'd21, 16'h55, 6'd0, 1'b0);
    chk("t3_sync_err", bus.sync_err, 1'b1);
    step(1'b1, 1'b1, 6'd22, 16'h56, 6'd0, 1'b0);
    chk("t3_sync_err_pulse", bus.sync_err, 1'b0);
    for (int k = 23; k < 63; k++) step(1'b1, 1'b1, 6'(k), 16'(k), 6'd0, 1'b0);
    chk("t3_no_valid", bus.frame_valid, 1'b0);

    // Overrun: A held, B dropped, then C after release.
    do_reset();
    fill_frame(16'h1000, 1'b0);
    chk("t4_a_valid", bus.frame_valid, 1'b1);
    chk("t4_a_no_overrun", bus.overrun, 1'b0);
    fill_frame(16'h2000, 1'b0);
    chk("t4_b_overrun", bus.overrun, 1'b1);
    read_frame(16'h1000);
    chk("t4_overrun_pulse", bus.overrun, 1'b0);
    step(1'b1, 1'b0, 6'd0, 16'h0, 6'd0, 1'b1);
    chk("t4_released", bus.frame_valid, 1'b0);
    fill_frame(16'h3000, 1'b0);
    chk("t4_c_valid", bus.frame_valid, 1'b1);
    chk("t4_c_no_overrun", bus.overrun, 1'b0);
    read_frame(16'h3000);

    // Release coincides with completion.
    fill_frame(16'h4000, 1'b1);
    chk("t5_valid", bus.frame_valid, 1'b1);
    chk("t5_no_overrun", bus.overrun, 1'b0);
    read_frame(16'h4000);

    // Reset mid-frame while a frame is held.
    for (int k = 0; k < 30; k++) step(1'b1, 1'b1, 6'(k + 63), 16'(k), 6'd0, 1'b0);
    step(1'b0, 1'b1, 6'd29, 16'h77, 6'd0, 1'b0);
    chk("t6_valid_cleared", bus.frame_valid, 1'b0);
    chk("t6_no_sync_err", bus.sync_err, 1'b0);
    for (int k = 30; k < 40; k++) step(1'b1, 1'b1, 6'(k), 16'(k), 6'd0, 1'b0);
    chk("t6_ignored", bus.frame_valid, 1'b0);
    fill_frame(16'h5000, 1'b0);
    chk("t6_recovered", bus.frame_valid, 1'b1);
    read_frame(16'h5000);

    // Randomized strobes with occasional jumps, releases and resets.
    do_reset();
    rc = 63;
    for (int i = 0; i < 5000; i++) begin
      bit r, en, rel;
      r   = ($urandom_range(0, 399) != 0);
      en  = ($urandom_range(0, 9) < 7);
      rel = ($urandom_range(0, 39) == 0);
      if (en && $urandom_range(0, 79) == 0) rc = $urandom_range(0, 63);
      step(r, en, 6'(rc), 16'($urandom), 6'($urandom_range(0, 63)), rel);
      if (en) rc = (rc + 1) % 64;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
